// File: rtl/tetris_input_ctrl_pkg.sv
// Shared key indices and repeat-FSM states for the tetris input path and game core.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tetris_pkg;

  typedef enum logic [2:0] {
    KEY_LEFT,
    KEY_RIGHT,
    KEY_DOWN,
    KEY_ROTATE,
    KEY_DROP
  } key_idx_e;

  localparam int NUM_KEYS = 5;

  typedef enum logic [1:0] {
    IDLE,
    DAS_WAIT,
    REPEAT
  } rep_state_e;

endpackage

// File: rtl/tetris_input_ctrl_if.sv
// Button-level inputs, enable and one-cycle key pulses between the board and the input stage.
// Latency: n/a (wiring only).
// Backpressure: none; key pulses are fire-and-forget.
interface tetris_input_ctrl_if;

  logic enable;
  logic btn_left;
  logic btn_right;
  logic btn_down;
  logic btn_rotate;
  logic btn_drop;
  logic key_left;
  logic key_right;
  logic key_down;
  logic key_rotate;
  logic key_drop;

  // Board / stimulus side: drives raw buttons and enable, observes key pulses.
  modport master (
    output enable, btn_left, btn_right, btn_down, btn_rotate, btn_drop,
    input  key_left, key_right, key_down, key_rotate, key_drop
  );

  // Input-conditioning block side.
  modport slave (
    input  enable, btn_left, btn_right, btn_down, btn_rotate, btn_drop,
    output key_left, key_right, key_down, key_rotate, key_drop
  );

endinterface

// File: rtl/tetris_input_ctrl_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer for one raw button.
// Latency: raw edge to deb change = DEBOUNCE_CYCLES+2 cycles when the input stays stable.
// Backpressure: none; deb is a continuously valid level.
module input_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic deb
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous button level into the clk domain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Count consecutive disagreeing cycles; flip deb only after a full stable run.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      deb <= 1'b0;
    end else if (sync2 == deb) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      deb <= sync2;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tetris_input_ctrl.sv
// Debounces five buttons and produces registered one-cycle key pulses with DAS/ARR on moves.
// Latency: stable raw press to first pulse = DEBOUNCE_CYCLES+3 cycles.
// Backpressure: none; enable=0 silences outputs and parks the repeat FSMs.
module tetris_input_ctrl
  import tetris_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int DAS_CYCLES      = 16_000_000,
  parameter int ARR_CYCLES      = 5_000_000,
  parameter int CNT_W           = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  tetris_input_ctrl_if.slave bus
);

  // Movement keys occupy key indices 0..2 (left, right, down), so the
  // repeat FSM arrays are indexed directly by key_idx_e for those keys.
  localparam int NUM_MOVE = 3;

  localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_CYCLES - 1);
  localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_CYCLES - 1);

  logic [NUM_KEYS-1:0] raw;
  logic [NUM_KEYS-1:0] deb;
  logic [NUM_KEYS-1:0] arm;
  logic [NUM_KEYS-1:0] held;
  logic [NUM_KEYS-1:0] pulse;
  logic [NUM_KEYS-1:0] key_q;
  logic [1:0]          tap_q;     // previous debounced level of {drop, rotate}

  logic [NUM_MOVE-1:0] mv_pulse;
  logic [NUM_MOVE-1:0] mv_block;
  logic                lr_conflict;
  logic                rot_pulse;
  logic                drop_pulse;

  rep_state_e          state     [NUM_MOVE];
  rep_state_e          state_nxt [NUM_MOVE];
  logic [CNT_W-1:0]    rcnt      [NUM_MOVE];
  logic [CNT_W-1:0]    rcnt_nxt  [NUM_MOVE];

  assign raw = {bus.btn_drop, bus.btn_rotate, bus.btn_down, bus.btn_right, bus.btn_left};

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_deb
    input_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw[g]),
      .deb  (deb[g])
    );
  end

  // A key only counts as held once it has been seen released while enabled,
  // so a button held across enable 0->1 stays silent until re-pressed.
  assign held        = deb & arm;
  assign lr_conflict = held[KEY_LEFT] & held[KEY_RIGHT];

  assign mv_block[KEY_LEFT]  = ~bus.enable | ~held[KEY_LEFT]  | lr_conflict;
  assign mv_block[KEY_RIGHT] = ~bus.enable | ~held[KEY_RIGHT] | lr_conflict;
  assign mv_block[KEY_DOWN]  = ~bus.enable | ~held[KEY_DOWN];

  assign rot_pulse  = bus.enable & held[KEY_ROTATE] & ~tap_q[0];
  assign drop_pulse = bus.enable & held[KEY_DROP]   & ~tap_q[1];

  // Repeat FSMs: a level-triggered IDLE exit makes a key that survives a
  // left/right conflict behave exactly like a fresh press.
  always_comb begin
    for (int k = 0; k < NUM_MOVE; k++) begin
      state_nxt[k] = state[k];
      rcnt_nxt[k]  = rcnt[k];
      mv_pulse[k]  = 1'b0;
      if (mv_block[k]) begin
        state_nxt[k] = IDLE;
        rcnt_nxt[k]  = '0;
      end else begin
        case (state[k])
          IDLE: begin
            mv_pulse[k]  = 1'b1;
            state_nxt[k] = DAS_WAIT;
            rcnt_nxt[k]  = '0;
          end
          DAS_WAIT: begin
            if (rcnt[k] == DAS_LAST) begin
              mv_pulse[k]  = 1'b1;
              state_nxt[k] = REPEAT;
              rcnt_nxt[k]  = '0;
            end else begin
              rcnt_nxt[k] = rcnt[k] + CNT_W'(1);
            end
          end
          REPEAT: begin
            if (rcnt[k] == ARR_LAST) begin
              mv_pulse[k] = 1'b1;
              rcnt_nxt[k] = '0;
            end else begin
              rcnt_nxt[k] = rcnt[k] + CNT_W'(1);
            end
          end
          default: begin
            state_nxt[k] = IDLE;
            rcnt_nxt[k]  = '0;
          end
        endcase
      end
    end
  end

  // Hard drop wins over soft drop in the same cycle; the down FSM keeps its timing.
  always_comb begin
    pulse              = '0;
    pulse[KEY_LEFT]    = mv_pulse[KEY_LEFT];
    pulse[KEY_RIGHT]   = mv_pulse[KEY_RIGHT];
    pulse[KEY_DOWN]    = mv_pulse[KEY_DOWN] & ~drop_pulse;
    pulse[KEY_ROTATE]  = rot_pulse;
    pulse[KEY_DROP]    = drop_pulse;
  end

  // Repeat FSM state and DAS/ARR counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_MOVE; k++) begin
        state[k] <= IDLE;
        rcnt[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_MOVE; k++) begin
        state[k] <= state_nxt[k];
        rcnt[k]  <= rcnt_nxt[k];
      end
    end
  end

  // Arm flags, tap-key edge history and the registered key outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      arm   <= '0;
      tap_q <= '0;
      key_q <= '0;
    end else begin
      arm   <= bus.enable ? (arm | ~deb) : '0;
      tap_q <= {deb[KEY_DROP], deb[KEY_ROTATE]};
      key_q <= pulse;
    end
  end

  assign bus.key_left   = key_q[KEY_LEFT];
  assign bus.key_right  = key_q[KEY_RIGHT];
  assign bus.key_down   = key_q[KEY_DOWN];
  assign bus.key_rotate = key_q[KEY_ROTATE];
  assign bus.key_drop   = key_q[KEY_DROP];

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Scoreboard bench for tetris_input_ctrl with short debounce/DAS/ARR settings.
// Latency: expected pulses are scheduled 7 cycles after the driving raw edge.
// Backpressure: none; every output pulse is matched against the expected queue.
module tb_tetris_input_ctrl;
  import tetris_pkg::*;

  localparam logic [4:0] M_LEFT  = 5'b00001;
  localparam logic [4:0] M_RIGHT = 5'b00010;
  localparam logic [4:0] M_ROT   = 5'b01000;
  localparam logic [4:0] M_DROP  = 5'b10000;
  localparam int         LAT     = 7;

  typedef struct {
    int         cyc;
    logic [4:0] mask;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  logic [4:0] k_now;
  exp_t       sb[$];

  tetris_input_ctrl_if bus ();

  tetris_input_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .DAS_CYCLES     (20),
    .ARR_CYCLES     (8),
    .CNT_W          (32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Count posedges; sampled and driven on the following negedge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] keys();
    return {bus.key_drop, bus.key_rotate, bus.key_down, bus.key_right, bus.key_left};
  endfunction

  task automatic exp_pulse(input int c, input logic [4:0] m);
    exp_t e;
    e.cyc  = c;
    e.mask = m;
    sb.push_back(e);
  endtask

  task automatic set_btn(input key_idx_e k, input logic v);
    case (k)
      KEY_LEFT:   bus.btn_left   = v;
      KEY_RIGHT:  bus.btn_right  = v;
      KEY_DOWN:   bus.btn_down   = v;
      KEY_ROTATE: bus.btn_rotate = v;
      KEY_DROP:   bus.btn_drop   = v;
      default:    ;
    endcase
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: every cycle either matches the head of the queue or must be silent.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      k_now = keys();
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        chk($sformatf("pulse@%0d", cyc), 32'(k_now), 32'(sb[0].mask));
        void'(sb.pop_front());
      end else if (k_now != 5'b0) begin
        chk($sformatf("spurious@%0d", cyc), 32'(k_now), 32'd0);
      end
    end
  end

  initial begin
    int r;
    int p;
    rst_n          = 1'b0;
    bus.enable     = 1'b1;
    bus.btn_left   = 1'b0;
    bus.btn_right  = 1'b0;
    bus.btn_down   = 1'b0;
    bus.btn_rotate = 1'b1;
    bus.btn_drop   = 1'b0;

    // 1: reset with rotate held, fresh press afterwards
    repeat (3) begin
      @(negedge clk);
      chk("reset_outputs", 32'(keys()), 32'd0);
    end
    rst_n = 1'b1;
    exp_pulse(cyc + LAT, M_ROT);
    wait_n(12);
    set_btn(KEY_ROTATE, 1'b0);
    wait_n(20);

    // 2: bouncing left, then a clean press
    for (int i = 0; i < 10; i++) begin
      set_btn(KEY_LEFT, 1'b1);
      wait_n(2);
      set_btn(KEY_LEFT, 1'b0);
      wait_n(2);
    end
    set_btn(KEY_LEFT, 1'b1);
    exp_pulse(cyc + LAT, M_LEFT);
    wait_n(12);
    set_btn(KEY_LEFT, 1'b0);
    wait_n(20);

    // 3: right held through DAS and several ARR repeats
    set_btn(KEY_RIGHT, 1'b1);
    begin
      int t0;
      t0 = cyc + LAT;
      exp_pulse(t0, M_RIGHT);
      for (int j = 0; j < 5; j++) exp_pulse(t0 + 20 + 8 * j, M_RIGHT);
    end
    wait_n(57);
    set_btn(KEY_RIGHT, 1'b0);
    wait_n(30);

    // 4: rotate held long; drop and down together -> drop wins
    set_btn(KEY_ROTATE, 1'b1);
    exp_pulse(cyc + LAT, M_ROT);
    wait_n(10);
    set_btn(KEY_DROP, 1'b1);
    set_btn(KEY_DOWN, 1'b1);
    exp_pulse(cyc + LAT, M_DROP);
    wait_n(12);
    set_btn(KEY_DROP, 1'b0);
    set_btn(KEY_DOWN, 1'b0);
    wait_n(78);
    set_btn(KEY_ROTATE, 1'b0);
    wait_n(20);

    // 5: left/right conflict, then right released
    set_btn(KEY_LEFT, 1'b1);
    exp_pulse(cyc + LAT, M_LEFT);
    wait_n(10);
    set_btn(KEY_RIGHT, 1'b1);
    wait_n(30);
    set_btn(KEY_RIGHT, 1'b0);
    r = cyc;
    exp_pulse(r + LAT, M_LEFT);
    exp_pulse(r + LAT + 20, M_LEFT);
    wait_n(22);
    set_btn(KEY_LEFT, 1'b0);
    wait_n(20);

    // 6: key held across enable 0->1 stays silent until re-pressed
    bus.enable = 1'b0;
    set_btn(KEY_LEFT, 1'b1);
    wait_n(20);
    bus.enable = 1'b1;
    wait_n(30);
    set_btn(KEY_LEFT, 1'b0);
    wait_n(15);
    set_btn(KEY_LEFT, 1'b1);
    p = cyc;
    exp_pulse(p + LAT, M_LEFT);
    wait_n(12);
    set_btn(KEY_LEFT, 1'b0);
    wait_n(30);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
